// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave pipelined Wishbone arbiter with fixed-priority or round-robin grant.
// Ownership lasts a full CYC, and strobes are throttled by a per-owner outstanding-request limit.
module wb_arbiter_n #(
    parameter int NUM_MASTERS      = 4,
    parameter int AW               = 32,
    parameter int DW               = 32,
    parameter int MODE             = 0,
    parameter int MAX_OUT          = 4,
    parameter int OPT_ZERO_ON_IDLE = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_sel,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [NUM_MASTERS-1:0]        m_stall,
    output logic                          o_cyc,
    output logic                          o_stb,
    output logic                          o_we,
    output logic [AW-1:0]                 o_adr,
    output logic [DW-1:0]                 o_dat,
    output logic [DW/8-1:0]               o_sel,
    input  logic                          o_ack,
    input  logic                          o_err,
    input  logic                          o_stall,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          state_own,
    output logic [$clog2(MAX_OUT+1)-1:0]  outstanding
);
    localparam int NM = NUM_MASTERS;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = DW / 8;

    // Handshake: a strobe transfers on o_stb && !o_stall; each o_ack/o_err retires a transfer.
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t        state, state_next;
    logic [IW-1:0] owner, winner, rr_ptr;
    logic          found;
    logic [CW-1:0] count;
    logic          at_limit, accept, ack_cnt;
    int            idx;

    assign at_limit    = (count == CW'(MAX_OUT));
    assign accept      = o_stb && !o_stall;
    assign ack_cnt     = (state == OWN) && o_ack && (count != '0);
    assign state_own   = (state == OWN);
    assign outstanding = count;

    // Reverse scans so the last hit is the lowest index / nearest after rr_ptr.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (MODE == 0) begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (m_cyc[i]) begin
                    winner = IW'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = NM; k >= 1; k--) begin
                idx = (int'(rr_ptr) + k) % NM;
                if (m_cyc[idx]) begin
                    winner = IW'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        o_cyc      = 1'b0;
        o_stb      = 1'b0;
        m_stall    = '1;
        m_ack      = '0;
        m_err      = '0;
        grant      = '0;
        case (state)
            IDLE: begin
                if (found) state_next = OWN;
            end
            OWN: begin
                o_cyc          = m_cyc[owner];
                o_stb          = m_stb[owner] && !at_limit;
                m_stall[owner] = o_stall || at_limit;
                m_ack[owner]   = o_ack;
                m_err[owner]   = o_err;
                grant[owner]   = 1'b1;
                if (!m_cyc[owner]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath mux stays on the last owner while idle unless zeroing is enabled.
    always_comb begin
        o_we  = m_we[owner];
        o_adr = m_adr[owner*AW +: AW];
        o_dat = m_dat[owner*DW +: DW];
        o_sel = m_sel[owner*SW +: SW];
        if (OPT_ZERO_ON_IDLE != 0 && state == IDLE) begin
            o_we  = 1'b0;
            o_adr = '0;
            o_dat = '0;
            o_sel = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= IW'(NM - 1);
            count  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) owner <= winner;
            if (state == OWN) begin
                if (!m_cyc[owner]) begin
                    rr_ptr <= owner;
                    count  <= '0;
                end else if (o_err) begin
                    count <= '0;
                end else if (accept && !ack_cnt) begin
                    count <= count + CW'(1);
                end else if (!accept && ack_cnt) begin
                    count <= count - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: a fixed-priority and a round-robin instance share one set of stimulus.
// Round-robin grant order is scoreboarded through an expected queue; everything else is checked inline.
module tb_wb_arbiter_n;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MAX_OUT = 2;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [NM-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [NM*AW-1:0] m_adr = '0;
    logic [NM*DW-1:0] m_dat = '0;
    logic [NM*SW-1:0] m_sel = '0;
    logic o_ack = 1'b0, o_err = 1'b0, o_stall = 1'b0;

    logic [NM-1:0] fp_ack, fp_err, fp_stall, fp_grant;
    logic [NM-1:0] rr_ack, rr_err, rr_stall, rr_grant;
    logic          fp_cyc, fp_stb, fp_we, fp_own, rr_cyc, rr_stb, rr_we, rr_own;
    logic [AW-1:0] fp_adr, rr_adr;
    logic [DW-1:0] fp_dat, rr_dat;
    logic [SW-1:0] fp_sel, rr_sel;
    logic [CW-1:0] fp_cnt, rr_cnt;

    logic [NM-1:0] exp_q[$];
    logic [NM-1:0] sb_exp;
    logic [NM-1:0] rr_grant_d = '0;
    bit            sb_on = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    wb_arbiter_n #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .MODE(0), .MAX_OUT(MAX_OUT),
                   .OPT_ZERO_ON_IDLE(0)) dut_fp (
        .CLK(CLK), .RST(RST), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat(m_dat), .m_sel(m_sel), .m_ack(fp_ack), .m_err(fp_err), .m_stall(fp_stall),
        .o_cyc(fp_cyc), .o_stb(fp_stb), .o_we(fp_we), .o_adr(fp_adr), .o_dat(fp_dat),
        .o_sel(fp_sel), .o_ack(o_ack), .o_err(o_err), .o_stall(o_stall), .grant(fp_grant),
        .state_own(fp_own), .outstanding(fp_cnt));

    wb_arbiter_n #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .MODE(1), .MAX_OUT(MAX_OUT),
                   .OPT_ZERO_ON_IDLE(0)) dut_rr (
        .CLK(CLK), .RST(RST), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat(m_dat), .m_sel(m_sel), .m_ack(rr_ack), .m_err(rr_err), .m_stall(rr_stall),
        .o_cyc(rr_cyc), .o_stb(rr_stb), .o_we(rr_we), .o_adr(rr_adr), .o_dat(rr_dat),
        .o_sel(rr_sel), .o_ack(o_ack), .o_err(o_err), .o_stall(o_stall), .grant(rr_grant),
        .state_own(rr_own), .outstanding(rr_cnt));

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < NM; i++) begin
            m_adr[i*AW +: AW] = $urandom;
            m_dat[i*DW +: DW] = $urandom;
            m_sel[i*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
            m_we[i]           = 1'($urandom_range(0, 1));
        end
    endtask

    // Scoreboard: each new round-robin ownership pops the next expected grant.
    always @(negedge CLK) begin
        if (sb_on && rr_grant != '0 && rr_grant_d == '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", 64'(rr_grant), 64'(0));
            end else begin
                sb_exp = exp_q.pop_front();
                check("rr_grant_order", 64'(rr_grant), 64'(sb_exp));
            end
        end
        rr_grant_d = rr_grant;
    end

    initial begin
        int g;
        load_data();
        step();
        step();
        check("rst_grant", 64'(fp_grant), 64'(0));
        check("rst_cyc_stb", 64'({fp_cyc, fp_stb}), 64'(0));
        check("rst_stall", 64'(fp_stall), 64'hF);
        check("rst_ack", 64'(fp_ack), 64'(0));
        check("rst_count", 64'(fp_cnt), 64'(0));

        // One cycle of arbitration latency, then master 1 owns in both modes
        RST   = 1'b0;
        m_cyc = 4'b1010;
        settle();
        check("t1_idle_grant", 64'(fp_grant), 64'(0));
        step();
        check("t1_grant", 64'(fp_grant), 64'(4'b0010));
        check("t1_cyc", 64'(fp_cyc), 64'(1));
        check("t1_stall", 64'(fp_stall), 64'(4'b1101));
        check("t1_rr_grant", 64'(rr_grant), 64'(4'b0010));
        check("t1_adr", 64'(fp_adr), 64'(m_adr[1*AW +: AW]));

        // Outstanding limit of 2: third strobe stalls until an ack
        m_stb = 4'b0010;
        settle();
        check("t3_stb_first", 64'(fp_stb), 64'(1));
        step();
        check("t3_stb_second", 64'(fp_stb), 64'(1));
        step();
        check("t3_stb_blocked", 64'(fp_stb), 64'(0));
        check("t3_stall_blocked", 64'(fp_stall), 64'hF);
        check("t3_count_full", 64'(fp_cnt), 64'(2));
        o_ack = 1'b1;
        settle();
        check("t3_ack_steer", 64'(fp_ack), 64'(4'b0010));
        step();
        o_ack = 1'b0;
        settle();
        check("t3_stb_resumed", 64'(fp_stb), 64'(1));
        check("t3_stall_resumed", 64'(fp_stall), 64'(4'b1101));

        // Accept and ack on the same edge leave the count unchanged
        step();
        m_stb = '0;
        o_ack = 1'b1;
        settle();
        check("t4_count_two", 64'(fp_cnt), 64'(2));
        step();
        m_stb = 4'b0010;
        settle();
        check("t4_count_one", 64'(fp_cnt), 64'(1));
        check("t4_stb_with_ack", 64'(fp_stb), 64'(1));
        step();
        m_stb = '0;
        o_ack = 1'b0;
        settle();
        check("t4_same_edge", 64'(fp_cnt), 64'(1));

        // Error during a 2-deep burst clears the count and hits the owner only
        m_stb = 4'b0010;
        step();
        m_stb = '0;
        settle();
        check("t5_count_two", 64'(fp_cnt), 64'(2));
        o_err = 1'b1;
        settle();
        check("t5_err_steer", 64'(fp_err), 64'(4'b0010));
        check("t5_err_steer_rr", 64'(rr_err), 64'(4'b0010));
        step();
        o_err = 1'b0;
        settle();
        check("t5_count_clear", 64'(fp_cnt), 64'(0));
        m_cyc = '0;
        step();
        check("t5_idle_grant", 64'(fp_grant), 64'(0));
        check("t5_idle_cyc", 64'(fp_cyc), 64'(0));
        check("t5_idle_stall", 64'(fp_stall), 64'hF);
        check("t5_idle_adr_held", 64'(fp_adr), 64'(m_adr[1*AW +: AW]));
        o_ack = 1'b1;
        settle();
        check("t4_idle_ack_drop", 64'(fp_ack), 64'(0));
        o_ack = 1'b0;

        // Reset while owning with one outstanding request
        m_cyc = 4'b0001;
        step();
        m_stb = 4'b0001;
        settle();
        check("t6_grant", 64'(fp_grant), 64'(4'b0001));
        step();
        m_stb = '0;
        settle();
        check("t6_count_one", 64'(fp_cnt), 64'(1));
        RST = 1'b1;
        step();
        RST   = 1'b0;
        m_cyc = '0;
        settle();
        check("t6_cyc", 64'(fp_cyc), 64'(0));
        check("t6_grant_clear", 64'(fp_grant), 64'(0));
        check("t6_count_clear", 64'(fp_cnt), 64'(0));
        o_ack = 1'b1;
        step();
        check("t6_late_ack", 64'(fp_ack), 64'(0));
        o_ack = 1'b0;

        // Round-robin rotation with all masters requesting
        RST = 1'b1;
        step();
        RST = 1'b0;
        load_data();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        sb_on = 1'b1;
        m_cyc = 4'hF;
        for (int k = 0; k < 5; k++) begin
            g = k % NM;
            step();
            m_stb = NM'(1) << g;
            settle();
            check("t2_adr", 64'(rr_adr), 64'(m_adr[g*AW +: AW]));
            check("t2_stb", 64'(rr_stb), 64'(1));
            step();
            m_stb = '0;
            o_ack = 1'b1;
            settle();
            check("t2_ack_steer", 64'(rr_ack), 64'(NM'(1) << g));
            step();
            o_ack = 1'b0;
            m_cyc = 4'hF & ~(NM'(1) << g);
            step();
            m_cyc = 4'hF;
        end
        m_cyc = '0;
        step();
        step();
        sb_on = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
